// File: rtl/sal_axi_traffic_gen_if.sv
// AXI3 write/read channel bundle between the traffic generator (master) and the memory under test (slave).
// Handshake rule on every channel: a transfer completes on the rising edge where valid and ready are both 1; the source holds valid and payload stable until then.
interface sal_axi_traffic_gen_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [3:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;

  logic [ID_WIDTH-1:0]     wid;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [3:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/sal_axi_traffic_gen.sv
// AXI3 traffic generator: writes address-derived patterns in strided bursts, then reads them back and
// counts mismatching beats / bad responses. One burst outstanding at a time.
module sal_axi_traffic_gen #(
  parameter int                 ADDR_WIDTH = 32,
  parameter int                 DATA_WIDTH = 64,
  parameter int                 ID_WIDTH   = 4,
  parameter int                 CNT_WIDTH  = 16,
  parameter logic [31:0]        SEED       = 32'hA5A5_0000,
  parameter logic [ID_WIDTH-1:0] TXN_ID    = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [CNT_WIDTH-1:0]  num_txn,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] stride,
  input  logic [3:0]            burst_len,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [2:0]            dbg_state,
  sal_axi_traffic_gen_if.master axi
);

  localparam int       BYTES = DATA_WIDTH / 8;
  localparam int       LANES = DATA_WIDTH / 32;
  localparam logic [2:0] SIZE = 3'($clog2(BYTES));

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    WR_RESP = 3'd3,
    RD_ADDR = 3'd4,
    RD_DATA = 3'd5,
    FINISH  = 3'd6
  } state_t;

  state_t                state_q, state_d;
  logic                  rd_after_wr_q, rd_after_wr_d;
  logic [CNT_WIDTH-1:0]  num_q, num_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  logic [3:0]            len_q, len_d;
  logic [CNT_WIDTH-1:0]  txn_q, txn_d;
  logic [ADDR_WIDTH-1:0] burst_addr_q, burst_addr_d;
  logic [3:0]            beat_q, beat_d;
  logic [ADDR_WIDTH-1:0] beat_addr_q, beat_addr_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wlast_q, wlast_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
  logic [ADDR_WIDTH-1:0] first_err_q, first_err_d;

  // Pattern key is the low 32 address bits, zero-extended for narrow address buses.
  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a);
    logic [63:0] ext;
    ext = 64'(a);
    return {LANES{ext[31:0] ^ SEED}};
  endfunction

  logic [ADDR_WIDTH-1:0] next_burst_addr;
  logic [ADDR_WIDTH-1:0] next_beat_addr;
  logic [3:0]            beat_inc;
  logic [CNT_WIDTH-1:0]  txn_inc;
  logic                  b_bad;
  logic                  r_bad;
  logic                  log_err;
  logic [ADDR_WIDTH-1:0] log_addr;

  assign next_burst_addr = burst_addr_q + stride_q;
  assign next_beat_addr  = beat_addr_q + ADDR_WIDTH'(BYTES);
  assign beat_inc        = beat_q + 4'd1;
  assign txn_inc         = txn_q + CNT_WIDTH'(1);
  assign b_bad = (axi.bresp != 2'b00) || (axi.bid != TXN_ID);
  assign r_bad = (axi.rresp != 2'b00) || (axi.rid != TXN_ID) ||
                 (axi.rdata != pattern(beat_addr_q)) || (axi.rlast != (beat_q == len_q));

  always_comb begin
    state_d       = state_q;
    rd_after_wr_d = rd_after_wr_q;
    num_d         = num_q;
    base_d        = base_q;
    stride_d      = stride_q;
    len_d         = len_q;
    txn_d         = txn_q;
    burst_addr_d  = burst_addr_q;
    beat_d        = beat_q;
    beat_addr_d   = beat_addr_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    wdata_d       = wdata_q;
    wlast_d       = wlast_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    busy_d        = busy_q;
    done_d        = done_q;
    err_cnt_d     = err_cnt_q;
    first_err_d   = first_err_q;
    log_err       = 1'b0;
    log_addr      = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          rd_after_wr_d = mode[1];
          num_d         = num_txn;
          base_d        = base_addr;
          stride_d      = stride;
          len_d         = burst_len;
          txn_d         = '0;
          burst_addr_d  = base_addr;
          err_cnt_d     = '0;
          first_err_d   = '0;
          if (num_txn == '0) begin
            done_d  = 1'b1;
            state_d = FINISH;
          end else begin
            busy_d = 1'b1;
            if (mode == 2'd1) begin
              arvalid_d = 1'b1;
              state_d   = RD_ADDR;
            end else begin
              awvalid_d = 1'b1;
              state_d   = WR_ADDR;
            end
          end
        end
      end

      WR_ADDR: begin
        if (axi.awready) begin
          awvalid_d   = 1'b0;
          wvalid_d    = 1'b1;
          beat_d      = '0;
          beat_addr_d = burst_addr_q;
          wdata_d     = pattern(burst_addr_q);
          wlast_d     = (len_q == 4'd0);
          state_d     = WR_DATA;
        end
      end

      WR_DATA: begin
        if (axi.wready) begin
          if (wlast_q) begin
            wvalid_d = 1'b0;
            wlast_d  = 1'b0;
            wdata_d  = '0;
            bready_d = 1'b1;
            state_d  = WR_RESP;
          end else begin
            beat_d      = beat_inc;
            beat_addr_d = next_beat_addr;
            wdata_d     = pattern(next_beat_addr);
            wlast_d     = (beat_inc == len_q);
          end
        end
      end

      WR_RESP: begin
        if (axi.bvalid) begin
          log_err  = b_bad;
          log_addr = burst_addr_q;
          bready_d = 1'b0;
          txn_d    = txn_inc;
          if (txn_inc != num_q) begin
            burst_addr_d = next_burst_addr;
            awvalid_d    = 1'b1;
            state_d      = WR_ADDR;
          end else if (rd_after_wr_q) begin
            // Read-back phase walks the same address sequence from the start.
            txn_d        = '0;
            burst_addr_d = base_q;
            arvalid_d    = 1'b1;
            state_d      = RD_ADDR;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = FINISH;
          end
        end
      end

      RD_ADDR: begin
        if (axi.arready) begin
          arvalid_d   = 1'b0;
          rready_d    = 1'b1;
          beat_d      = '0;
          beat_addr_d = burst_addr_q;
          state_d     = RD_DATA;
        end
      end

      RD_DATA: begin
        if (axi.rvalid) begin
          log_err  = r_bad;
          log_addr = beat_addr_q;
          // Burst ends on our own beat count; a misplaced rlast is only flagged, never trusted.
          if (beat_q == len_q) begin
            rready_d = 1'b0;
            txn_d    = txn_inc;
            if (txn_inc != num_q) begin
              burst_addr_d = next_burst_addr;
              arvalid_d    = 1'b1;
              state_d      = RD_ADDR;
            end else begin
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = FINISH;
            end
          end else begin
            beat_d      = beat_inc;
            beat_addr_d = next_beat_addr;
          end
        end
      end

      FINISH: begin
        done_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    if (log_err) begin
      if (err_cnt_q == '0) first_err_d = log_addr;
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rd_after_wr_q <= 1'b0;
      num_q         <= '0;
      base_q        <= '0;
      stride_q      <= '0;
      len_q         <= '0;
      txn_q         <= '0;
      burst_addr_q  <= '0;
      beat_q        <= '0;
      beat_addr_q   <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      wdata_q       <= '0;
      wlast_q       <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_cnt_q     <= '0;
      first_err_q   <= '0;
    end else begin
      state_q       <= state_d;
      rd_after_wr_q <= rd_after_wr_d;
      num_q         <= num_d;
      base_q        <= base_d;
      stride_q      <= stride_d;
      len_q         <= len_d;
      txn_q         <= txn_d;
      burst_addr_q  <= burst_addr_d;
      beat_q        <= beat_d;
      beat_addr_q   <= beat_addr_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      wdata_q       <= wdata_d;
      wlast_q       <= wlast_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_cnt_q     <= err_cnt_d;
      first_err_q   <= first_err_d;
    end
  end

  assign axi.awid    = TXN_ID;
  assign axi.awaddr  = burst_addr_q;
  assign axi.awlen   = len_q;
  assign axi.awsize  = awvalid_q ? SIZE : 3'd0;
  assign axi.awburst = awvalid_q ? 2'b01 : 2'b00;
  assign axi.awvalid = awvalid_q;

  assign axi.wid     = TXN_ID;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wvalid_q ? '1 : '0;
  assign axi.wlast   = wlast_q;
  assign axi.wvalid  = wvalid_q;

  assign axi.bready  = bready_q;

  assign axi.arid    = TXN_ID;
  assign axi.araddr  = burst_addr_q;
  assign axi.arlen   = len_q;
  assign axi.arsize  = arvalid_q ? SIZE : 3'd0;
  assign axi.arburst = arvalid_q ? 2'b01 : 2'b00;
  assign axi.arvalid = arvalid_q;

  assign axi.rready  = rready_q;

  assign busy           = busy_q;
  assign done           = done_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_err_q;
  assign dbg_state      = state_q;

endmodule

// File: doc/sal_axi_traffic_gen.md
SAL_AXI_TRAFFIC_GEN -- requirements
Module: sal_axi_traffic_gen

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low; ports clk and rst_n.
REQ-002 Parameter ADDR_WIDTH, default 32, SHALL set the AXI address width (range 12..64).
REQ-003 Parameter DATA_WIDTH, default 64, SHALL set the AXI data width (multiple of 32, range 32..512).
REQ-004 Parameter ID_WIDTH, default 4, SHALL set the AXI ID width.
REQ-005 Parameter CNT_WIDTH, default 16, SHALL set the width of the transaction and error counters.
REQ-006 Parameter SEED, default 32'hA5A5_0000, SHALL set the data-pattern XOR key.
REQ-007 Parameter TXN_ID, default 0, SHALL set the ID driven on all requests and expected on all responses.
REQ-008 clk  in  1  clock.
REQ-009 rst_n  in  1  synchronous active-low reset.
REQ-010 start  in  1  single-cycle request to begin a run.
REQ-011 mode  in  2  run mode: 0 write-only; 1 read-check; 2 write-all-then-read-check; 3 same as 2.
REQ-012 num_txn  in  CNT_WIDTH  number of bursts per phase.
REQ-013 base_addr  in  ADDR_WIDTH  address of the first burst.
REQ-014 stride  in  ADDR_WIDTH  address increment between consecutive bursts.
REQ-015 burst_len  in  4  AXI3 length; burst_len+1 beats per burst.
REQ-016 busy  out  1  run in progress.
REQ-017 done  out  1  single-cycle end-of-run pulse.
REQ-018 err_cnt  out  CNT_WIDTH  saturating count of errors in the current run.
REQ-019 first_err_addr  out  ADDR_WIDTH  beat address of the first error in the current run.
REQ-020 AW channel SHALL comprise awid, awaddr, awlen[3:0], awsize[2:0], awburst[1:0], awvalid (out) and awready (in).
REQ-021 W channel SHALL comprise wid, wdata, wstrb[DATA_WIDTH/8], wlast, wvalid (out) and wready (in).
REQ-022 B channel SHALL comprise bid, bresp[1:0], bvalid (in) and bready (out).
REQ-023 AR channel SHALL comprise arid, araddr, arlen, arsize, arburst, arvalid (out) and arready (in); R channel SHALL comprise rid, rdata, rresp, rlast, rvalid (in) and rready (out).

Function
REQ-024 start SHALL be accepted only in IDLE; mode, num_txn, base_addr, stride and burst_len SHALL be latched on acceptance; start while busy SHALL be ignored.
REQ-025 Acceptance SHALL clear err_cnt and first_err_addr to 0 and set busy on the next edge.
REQ-026 FSM states SHALL be IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA and FINISH.
REQ-027 FSM transitions SHALL be: IDLE->WR_ADDR (mode 0/2/3) or IDLE->RD_ADDR (mode 1); WR_ADDR->WR_DATA on AW handshake; WR_DATA->WR_RESP on the final W handshake; WR_RESP->WR_ADDR on B handshake if bursts remain.
REQ-028 After the last write burst, WR_RESP SHALL go to RD_ADDR in mode 2/3 and to FINISH in mode 0; RD_ADDR->RD_DATA on AR handshake; RD_DATA->RD_ADDR or FINISH after burst_len+1 R handshakes; FINISH->IDLE after one cycle.
REQ-029 In FINISH, done SHALL be 1 and busy SHALL be 0; num_txn=0 SHALL go IDLE->FINISH with no bus activity.
REQ-030 Burst t address SHALL be base_addr + t*stride mod 2^ADDR_WIDTH; beat b address SHALL be burst address + b*(DATA_WIDTH/8), also wrapping.
REQ-031 Beat data SHALL be DATA_WIDTH/32 copies of (beat_addr[31:0] XOR SEED), with beat_addr zero-extended when ADDR_WIDTH<32.
REQ-032 Request fields SHALL be awlen/arlen=burst_len, awsize/arsize=log2(DATA_WIDTH/8), awburst/arburst=2'b01, wstrb all ones, wlast on beat burst_len, and all IDs=TXN_ID.
REQ-033 Only one burst SHALL be outstanding; W SHALL start only after the AW handshake.
REQ-034 A valid SHALL stay asserted with a stable payload until its handshake; bready SHALL be 1 only in WR_RESP and rready only in RD_DATA.
REQ-035 The following SHALL each be an error: B handshake with bresp!=0 or bid!=TXN_ID (address = burst address); R beat with rresp!=0, rid!=TXN_ID, rdata!=pattern, or rlast!=(beat==burst_len).
REQ-036 Each erroneous beat or response SHALL add exactly 1 to err_cnt regardless of how many conditions fail; err_cnt SHALL saturate at all-ones.
REQ-037 first_err_addr SHALL be written only on the first error after acceptance; err_cnt and first_err_addr SHALL hold after done until the next accepted start.
REQ-038 RD_DATA SHALL exit on the beat count reaching burst_len+1 independent of rlast.

Reset
REQ-039 On any edge with rst_n=0, including mid-run, the state SHALL go to IDLE and all outputs (valids, readys, busy, done, err_cnt, first_err_addr, payloads) SHALL go to 0; no handshake completes on that edge.

Verification
REQ-040 Clean run: mode=2, num_txn=4, base=0x1000, stride=0x40, burst_len=3, ideal slave -> AW at 0x1000/0x1040/0x1080/0x10C0, awsize=3; first wdata 0xA5A51000A5A51000; 16 W and 16 R beats; done pulse; err_cnt=0.
REQ-041 Corruption: as in REQ-040 with rdata flipped on beat 2 of burst 1 -> err_cnt=1, first_err_addr=0x1050.
REQ-042 Backpressure: random ready/valid delays on all channels -> payloads stable while valid is high, results identical to REQ-040.
REQ-043 Response error: mode=0, num_txn=1, bresp=2'b10 -> err_cnt=1, first_err_addr=0x1000; no AR issued.
REQ-044 Boundaries: num_txn=0 -> done one cycle after acceptance with no valids; base=0xFFFFFFC0, stride=0x40, num_txn=2 -> second burst at 0x0; start while busy -> ignored.
REQ-045 Reset during WR_DATA -> next edge all valids, busy and err_cnt are 0; a following run completes as in REQ-040.
